// File: rtl/apb_gpio_master_arb_pkg.sv
// Shared definitions for the two-port APB master that fronts the GPIO bridge.
//   apb_state_t : transfer FSM states (IDLE / SETUP / ACCESS)
//   APB_ADDR_W  : default APB address width
//   APB_DATA_W  : default APB data width
//   apb_cmd_t   : one requester command {write, addr, wdata} at default widths
package apb_gpio_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_gpio_master_arb_if.sv
// APB bus between this master and the GPIO bridge slave port.
//   master modport : drives PSEL/PENABLE/PWRITE/PADDR/PWDATA, samples PRDATA/PREADY
//   slave  modport : the mirror image, used by the bridge (or a bench model)
interface apb_gpio_master_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );

endinterface

// File: rtl/apb_gpio_master_arb_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock and asynchronous active-low reset
//   req[1:0]   : requester valid lines
//   advance    : a grant was taken this cycle; remember it as the last winner
//   gnt_idx    : index of the granted requester (0 when nobody requests)
//   gnt_oh     : one-hot grant, all-zero when nobody requests
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt_idx,
  output logic [1:0] gnt_oh
);

  // Last granted index; resets to 1 so requester 0 wins the first tie.
  logic last;

  always_comb begin
    gnt_idx = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = 1'b0;
    endcase
    gnt_oh = (req == 2'b00) ? 2'b00 : (gnt_idx ? 2'b10 : 2'b01);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (advance) begin
      last <= gnt_idx;
    end
  end

endmodule

// File: rtl/apb_gpio_master_arb.sv
// Two-port APB master sharing the GPIO bridge slave port between two requesters.
//   PCLK, PRESETn         : clock, asynchronous active-low reset
//   reqN_valid/write/addr/wdata : command from requester N
//   reqN_ready            : command accepted this cycle (combinational, IDLE only)
//   reqN_done/err/rdata   : registered one-cycle completion, err=1 on timeout
//   apb                   : APB master side (PSEL/PENABLE/PWRITE/PADDR/PWDATA,
//                           PRDATA/PREADY)
// A command is latched on acceptance, driven through SETUP then ACCESS, and
// completes on PREADY or aborts after TIMEOUT_CYC-1 PREADY-low ACCESS cycles.
module apb_gpio_master_arb
  import apb_gpio_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,

  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  output logic              req0_err,
  output logic [DATA_W-1:0] req0_rdata,

  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic              req1_err,
  output logic [DATA_W-1:0] req1_rdata,

  apb_gpio_master_arb_if.master apb
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  apb_state_t        state;
  logic              owner;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_cnt_nxt;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;

  logic [1:0]        done;
  logic [1:0]        err;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  logic [1:0]        req_v;
  logic              gnt_idx;
  logic [1:0]        gnt_oh;
  logic [1:0]        accept;
  logic              take;

  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req_v = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .req     (req_v),
    .advance (take),
    .gnt_idx (gnt_idx),
    .gnt_oh  (gnt_oh)
  );

  // Ready is only offered from IDLE, so a command arriving in the done cycle
  // is still taken without an extra bubble.
  assign accept     = (state == IDLE) ? (gnt_oh & req_v) : 2'b00;
  assign take       = |accept;
  assign req0_ready = accept[0];
  assign req1_ready = accept[1];

  assign sel_write = gnt_idx ? req1_write : req0_write;
  assign sel_addr  = gnt_idx ? req1_addr  : req0_addr;
  assign sel_wdata = gnt_idx ? req1_wdata : req0_wdata;

  assign wait_cnt_nxt = wait_cnt + CNT_W'(1);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= IDLE;
      owner    <= 1'b0;
      wait_cnt <= '0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      done     <= 2'b00;
      err      <= 2'b00;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      // Responses are single-cycle pulses; rdata is zero outside them.
      done   <= 2'b00;
      err    <= 2'b00;
      rdata0 <= '0;
      rdata1 <= '0;
      case (state)
        IDLE: begin
          if (take) begin
            owner   <= gnt_idx;
            pwrite  <= sel_write;
            paddr   <= sel_addr;
            pwdata  <= sel_wdata;
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          // Abort once the counter would reach TIMEOUT_CYC-1 with PREADY low.
          if (apb.PREADY || (wait_cnt_nxt == CNT_LAST)) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            wait_cnt    <= '0;
            state       <= IDLE;
            done[owner] <= 1'b1;
            err[owner]  <= ~apb.PREADY;
            if (apb.PREADY && !pwrite) begin
              if (owner) rdata1 <= apb.PRDATA;
              else       rdata0 <= apb.PRDATA;
            end
          end else begin
            wait_cnt <= wait_cnt_nxt;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign apb.PSEL    = psel;
  assign apb.PENABLE = penable;
  assign apb.PWRITE  = pwrite;
  assign apb.PADDR   = paddr;
  assign apb.PWDATA  = pwdata;

  assign req0_done  = done[0];
  assign req1_done  = done[1];
  assign req0_err   = err[0];
  assign req1_err   = err[1];
  assign req0_rdata = rdata0;
  assign req1_rdata = rdata1;

endmodule

// File: doc/apb_gpio_master_arb.md
# apb_gpio_master_arb

Two-port APB master that shares the single APB slave port of the GPIO bridge (`apb_if`) between two on-chip requesters. Each requester issues simple valid/ready commands; the block arbitrates round-robin, runs the APB SETUP/ACCESS sequence, waits on PREADY with a bounded timeout, and returns read data and status to the granted requester. It sits directly upstream of `apb_if` on the PCLK domain.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 16, maximum ACCESS cycles with PREADY low before abort (≥2).

Ports:
- PCLK  in  1  single clock; all logic on its rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  command pending.
- req0_write / req1_write  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  ADDR_W  target address.
- req0_wdata / req1_wdata  in  DATA_W  write data.
- req0_ready / req1_ready  out  1  command accepted this cycle.
- req0_done / req1_done  out  1  one-cycle completion pulse.
- req0_err / req1_err  out  1  valid with done; 1 = timeout.
- req0_rdata / req1_rdata  out  DATA_W  read data, valid with done.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB slave ready.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: grant computed combinationally; reqN_ready = (state==IDLE) && grant==N && reqN_valid. A command transfers on the rising edge where valid && ready; the addr, wdata, and write fields and the grant index are latched; next state is SETUP.
- Arbitration: round-robin, 2-way. If both requesters are valid, grant goes to the one not granted last. If only one is valid, that one is granted. The last-grant pointer updates only on acceptance. After reset, last = 1, so req0 wins the first tie.
- SETUP (one cycle): PSEL=1, PENABLE=0, PWRITE/PADDR/PWDATA = latched values; next state is ACCESS unconditionally.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1 at an edge: capture PRDATA (reads only); pulse done for the granted requester with err=0; go to IDLE.
  - PREADY=0: increment the wait counter. When the counter reaches TIMEOUT_CYC-1 with PREADY still low, abort: done=1, err=1, rdata=0, go to IDLE.
- Writes: rdata on done is 0.
- The non-granted requester's done, err, and rdata stay 0.
- PADDR, PWDATA, and PWRITE hold their last values in IDLE; they do not toggle.
- A requester may deassert valid before ready; nothing is latched.
- A new command from the same requester may be issued in the same cycle its done pulses; it is accepted, since the state is IDLE in that cycle.

## Timing
- All outputs except reqN_ready are registered.
- Reset (async assert, sync-style release at the next edge): state=IDLE; PSEL, PENABLE, PWRITE = 0; PADDR and PWDATA = 0; all done, err, rdata = 0; wait counter = 0; last-grant = 1.
- Reset mid-transfer: the bus drops immediately; the in-flight command is lost; no done is issued.
- Latency with zero wait states:
  - Accept at edge E0.
  - SETUP during E0–E1.
  - ACCESS during E1–E2; PREADY sampled high at E2.
  - done high during E2–E3.
- Each PREADY-low cycle adds one cycle.
- Minimum issue interval: 3 cycles per transfer, because one IDLE cycle separates transfers.
- Timeout: done+err asserts TIMEOUT_CYC+1 cycles after acceptance.
- PREADY is ignored outside ACCESS.
- PRDATA is sampled only at the completing edge.

## Structure
- Shared package `apb_gpio_pkg`:
  - `apb_state_t` enum {IDLE, SETUP, ACCESS}.
  - Default widths ADDR_W/DATA_W.
  - Command struct {write, addr, wdata}.
- Sub-module `rr_arb2`:
  - Inputs: req[1:0], advance.
  - Outputs: grant index and a one-hot grant.
  - Holds the last-grant register.
- The top level contains the FSM, the command latch, the wait counter, and response steering.

## Test plan
- Reset: assert PRESETn=0 mid-ACCESS → PSEL, PENABLE, and every done drop in the same cycle; after release, the first tie goes to req0.
- Single read: req0 read 32'hf0f0_ffff, slave PREADY=1 on the first ACCESS cycle with PRDATA=201 → PSEL rises 1 cycle after ready, PENABLE 1 cycle later; req0_done with rdata=201 and err=0 3 cycles after acceptance.
- Write with waits: req1 write 32'hffff_0f0f data 201, PREADY held low 3 cycles → PWDATA=201 stable through ACCESS; req1_done 6 cycles after acceptance with err=0.
- Contention: both requesters valid continuously, 4 transfers → grants alternate 0,1,0,1; one IDLE cycle between transfers; no done on the wrong port.
- Timeout: PREADY tied low, TIMEOUT_CYC=16 → req0_done and req0_err=1 at 17 cycles after acceptance; rdata=0; the FSM accepts the next command from IDLE.
- Withdrawal: req1_valid pulses 1 cycle while a transfer is busy → not latched; no APB activity for it.
